sample_pair_buf: RTL and testbench

- Sits between the async FIFO read side and the DAC serializer in the playback path.
- Pops {sample, lrck} words from a first-word-fall-through FIFO and pairs them into aligned left/right frames.
- Holds one complete frame and presents it to the DAC side on a per-frame request.
- Repairs channel slips, mutes on underrun, drains the FIFO while the receiver is unlocked, and exposes diagnostic counters.

---
 rtl/dmix_pkg.sv | 18 +
 rtl/sample_pair_buf_sat_counter.sv | 32 +++
 rtl/sample_pair_buf.sv | 141 ++++++++++++++
 tb/tb_sample_pair_buf.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmix_pkg.sv
// Shared types and constants for the playback sample path.
// Pairing states, the lrck polarity that marks a left word, and the default sample width.
package dmix_pkg;

    typedef enum logic [1:0] {
        WAIT_L = 2'd0,
        WAIT_R = 2'd1,
        FULL   = 2'd2
    } state_t;

    localparam logic LRCK_LEFT            = 1'b1;
    localparam int   DEFAULT_SAMPLE_WIDTH = 24;

    function automatic logic is_left(input logic lrck);
        return (lrck == LRCK_LEFT);
    endfunction

endpackage

// File: rtl/sample_pair_buf_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk245760,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] value
);

    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 at_max_s;

    // Saturation detect
    always_comb begin
        at_max_s = (cnt_r == {CNT_WIDTH{1'b1}});
    end

    // Counter register
    always_ff @(posedge clk245760) begin
        if (clear) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (inc && !at_max_s) begin
            cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign value = cnt_r;

endmodule

// File: rtl/sample_pair_buf.sv
// Pairs {sample, lrck} words from a FWFT FIFO into left/right frames and hands
// one frame per request to the DAC serializer, muting or holding on underrun.
module sample_pair_buf
    import dmix_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_SAMPLE_WIDTH,
    parameter int UNDERRUN_MUTE = 1,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                  clk245760,
    input  logic                  rst,
    input  logic                  locked_i,
    input  logic [DATA_WIDTH:0]   fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_pop_o,
    input  logic                  dac_pop_i,
    output logic                  dac_ack_o,
    output logic [DATA_WIDTH-1:0] dac_left_o,
    output logic [DATA_WIDTH-1:0] dac_right_o,
    output logic [CNT_WIDTH-1:0]  underrun_cnt_o,
    output logic [CNT_WIDTH-1:0]  slip_cnt_o
);

    localparam logic MUTE = (UNDERRUN_MUTE != 0);

    state_t                state_r;
    logic [DATA_WIDTH-1:0] pend_l_r;
    logic [DATA_WIDTH-1:0] pend_r_r;
    logic [DATA_WIDTH-1:0] left_r;
    logic [DATA_WIDTH-1:0] right_r;
    logic                  ack_r;

    logic [DATA_WIDTH-1:0] head_sample_s;
    logic                  head_left_s;
    logic                  pop_s;
    logic                  serve_s;
    logic                  slip_inc_s;
    logic                  underrun_inc_s;

    // Head decode, pop request, and counter increment strobes
    always_comb begin
        head_sample_s  = fifo_data_i[DATA_WIDTH:1];
        head_left_s    = is_left(fifo_data_i[0]);
        pop_s          = 1'b0;
        slip_inc_s     = 1'b0;
        serve_s        = dac_pop_i && locked_i && (state_r == FULL);
        underrun_inc_s = dac_pop_i && !serve_s && !rst;
        if (rst || fifo_empty_i) begin
            pop_s = 1'b0;
        end else if (!locked_i) begin
            // Drain mode: everything is thrown away without counting as a slip
            pop_s = 1'b1;
        end else begin
            pop_s = (state_r != FULL);
            case (state_r)
                WAIT_L:  slip_inc_s = !head_left_s;
                WAIT_R:  slip_inc_s = head_left_s;
                FULL:    slip_inc_s = 1'b0;
                default: slip_inc_s = 1'b0;
            endcase
        end
    end

    // Pairing FSM with registered frame outputs and ack pulse
    always_ff @(posedge clk245760) begin
        if (rst) begin
            state_r  <= WAIT_L;
            pend_l_r <= {DATA_WIDTH{1'b0}};
            pend_r_r <= {DATA_WIDTH{1'b0}};
            left_r   <= {DATA_WIDTH{1'b0}};
            right_r  <= {DATA_WIDTH{1'b0}};
            ack_r    <= 1'b0;
        end else begin
            ack_r <= dac_pop_i;

            if (serve_s) begin
                left_r  <= pend_l_r;
                right_r <= pend_r_r;
            end else if (dac_pop_i && MUTE) begin
                left_r  <= {DATA_WIDTH{1'b0}};
                right_r <= {DATA_WIDTH{1'b0}};
            end else begin
                left_r  <= left_r;
                right_r <= right_r;
            end

            if (!locked_i) begin
                state_r  <= WAIT_L;
                pend_l_r <= {DATA_WIDTH{1'b0}};
                pend_r_r <= {DATA_WIDTH{1'b0}};
            end else if (serve_s) begin
                state_r <= WAIT_L;
            end else if (pop_s) begin
                case (state_r)
                    WAIT_L: begin
                        if (head_left_s) begin
                            pend_l_r <= head_sample_s;
                            state_r  <= WAIT_R;
                        end else begin
                            state_r  <= WAIT_L;
                        end
                    end
                    WAIT_R: begin
                        // A second left replaces the first; a right completes the pair
                        if (head_left_s) begin
                            pend_l_r <= head_sample_s;
                            state_r  <= WAIT_R;
                        end else begin
                            pend_r_r <= head_sample_s;
                            state_r  <= FULL;
                        end
                    end
                    FULL:    state_r <= FULL;
                    default: state_r <= WAIT_L;
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_underrun_cnt (
        .clk245760 (clk245760),
        .clear     (rst),
        .inc       (underrun_inc_s),
        .value     (underrun_cnt_o)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_slip_cnt (
        .clk245760 (clk245760),
        .clear     (rst),
        .inc       (slip_inc_s),
        .value     (slip_cnt_o)
    );

    assign fifo_pop_o  = pop_s;
    assign dac_ack_o   = ack_r;
    assign dac_left_o  = left_r;
    assign dac_right_o = right_r;

endmodule

// File: tb/tb_sample_pair_buf.sv
// Scoreboard bench: a muting and a holding instance share one FIFO model; a
// frame-level reference model predicts every pop, ack, frame and counter.
module tb_sample_pair_buf;

    logic        clk245760 = 1'b0;
    logic        rst = 1'b1;
    logic        locked = 1'b1;
    logic [24:0] fifo_data = 25'd0;
    logic        fifo_empty = 1'b1;
    logic        dac_pop = 1'b0;

    logic        pop_m, pop_h, ack_m, ack_h;
    logic [23:0] left_m, right_m, left_h, right_h;
    logic [7:0]  und_m, slp_m, und_h, slp_h;

    always #5 clk245760 = ~clk245760;

    sample_pair_buf #(.DATA_WIDTH(24), .UNDERRUN_MUTE(1), .CNT_WIDTH(8)) dut_m (
        .clk245760(clk245760), .rst(rst), .locked_i(locked),
        .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_pop_o(pop_m),
        .dac_pop_i(dac_pop), .dac_ack_o(ack_m), .dac_left_o(left_m), .dac_right_o(right_m),
        .underrun_cnt_o(und_m), .slip_cnt_o(slp_m)
    );

    sample_pair_buf #(.DATA_WIDTH(24), .UNDERRUN_MUTE(0), .CNT_WIDTH(8)) dut_h (
        .clk245760(clk245760), .rst(rst), .locked_i(locked),
        .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_pop_o(pop_h),
        .dac_pop_i(dac_pop), .dac_ack_o(ack_h), .dac_left_o(left_h), .dac_right_o(right_h),
        .underrun_cnt_o(und_h), .slip_cnt_o(slp_h)
    );

    typedef struct {
        logic [23:0] ml, mr, hl, hr;
        int          und, slp;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [24:0] fifo_q[$];
    exp_t        sb[$];

    // Reference model: partial pair, completed frame, last presented frames, counters
    int          partial[$];
    bit          frame_ready = 1'b0;
    logic [23:0] frame_l = 24'd0, frame_r = 24'd0;
    logic [23:0] mute_l = 24'd0, mute_r = 24'd0, hold_l = 24'd0, hold_r = 24'd0;
    int          und = 0, slp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : v;
    endfunction

    task automatic push_word(input logic [23:0] s, input logic lr);
        fifo_q.push_back({s, lr});
    endtask

    task automatic model_reset();
        partial.delete();
        frame_ready = 1'b0;
        frame_l = 24'd0; frame_r = 24'd0;
        mute_l = 24'd0; mute_r = 24'd0; hold_l = 24'd0; hold_r = 24'd0;
        und = 0; slp = 0;
    endtask

    // One clock: drive at the falling edge, check, then predict the next rising edge
    task automatic step(input bit r, input bit lk, input bit dp);
        bit          exp_pop;
        logic [24:0] w;
        exp_t        e;
        @(negedge clk245760);
        check("pending_acks", sb.size(), 0);
        sb.delete();
        rst = r; locked = lk; dac_pop = dp;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : 25'd0;
        #1;
        exp_pop = !r && (fifo_q.size() != 0) && (!lk || !frame_ready);
        check("fifo_pop_m", pop_m, exp_pop);
        check("fifo_pop_h", pop_h, exp_pop);
        check("underrun_cnt", und_m, und);
        check("slip_cnt", slp_h, slp);
        check("held_left_m", left_m, mute_l);
        check("held_right_h", right_h, hold_r);
        if (r) begin
            model_reset();
        end else begin
            if (dp) begin
                if (lk && frame_ready) begin
                    mute_l = frame_l; mute_r = frame_r;
                    hold_l = frame_l; hold_r = frame_r;
                    frame_ready = 1'b0;
                end else begin
                    und = sat_inc(und);
                    mute_l = 24'd0; mute_r = 24'd0;
                end
            end
            if (exp_pop) begin
                w = fifo_q.pop_front();
                if (lk) begin
                    if (partial.size() == 0) begin
                        if (w[0]) partial.push_back(int'(w[24:1]));
                        else slp = sat_inc(slp);
                    end else if (w[0]) begin
                        partial[0] = int'(w[24:1]);
                        slp = sat_inc(slp);
                    end else begin
                        frame_l = 24'(partial[0]);
                        frame_r = w[24:1];
                        partial.delete();
                        frame_ready = 1'b1;
                    end
                end
            end
            if (!lk) begin
                partial.delete();
                frame_ready = 1'b0;
            end
            if (dp) begin
                e.ml = mute_l; e.mr = mute_r; e.hl = hold_l; e.hr = hold_r;
                e.und = und; e.slp = slp;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: every ack must match the oldest expected frame
    always @(posedge clk245760) begin
        exp_t e;
        #1;
        if (ack_m === 1'b1 || ack_h === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", ack_m, 1'b0);
            end else begin
                e = sb.pop_front();
                check("ack_h", ack_h, 1'b1);
                check("ack_m", ack_m, 1'b1);
                check("frame_left_m", left_m, e.ml);
                check("frame_right_m", right_m, e.mr);
                check("frame_left_h", left_h, e.hl);
                check("frame_right_h", right_h, e.hr);
                check("ack_underrun_cnt", und_h, e.und);
                check("ack_slip_cnt", slp_m, e.slp);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lk;
        bit lr;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("reset_ack", ack_m, 1'b0);
        check("reset_left", left_h, 24'd0);

        // Normal pairing
        push_word(24'h123456, 1'b1); push_word(24'h654321, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b1);
        idle(1);
        check("pair_left", left_m, 24'h123456);
        check("pair_right", right_m, 24'h654321);

        // Leading right word is a slip
        push_word(24'h000001, 1'b0); push_word(24'h0000AA, 1'b1); push_word(24'h0000BB, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 1'b1);
        idle(1);
        check("lead_right_slip", slp_m, 8'd1);
        check("lead_right_left", left_h, 24'h0000AA);

        // Double left replaces the pending left
        push_word(24'h11, 1'b1); push_word(24'h22, 1'b1); push_word(24'h33, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 1'b1);
        idle(1);
        check("double_left_slip", slp_h, 8'd2);
        check("double_left_frame", left_m, 24'h22);

        // Underrun: mute versus hold
        push_word(24'h5, 1'b1); push_word(24'h6, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b1);
        idle(1);
        step(1'b0, 1'b1, 1'b1);
        idle(1);
        check("underrun_mute_left", left_m, 24'd0);
        check("underrun_hold_right", right_h, 24'h6);
        check("underrun_cnt_one", und_m, 8'd1);

        // Drain while unlocked
        for (int i = 0; i < 10; i++) push_word(24'(i + 100), i[0]);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
        check("drain_slip", slp_m, 8'd2);

        // Saturation of the underrun counter
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b1, 1'b0);
        end
        check("underrun_saturated", und_h, 8'd255);

        // Reset while holding a pending left
        push_word(24'hABCDEF, 1'b1);
        idle(2);
        step(1'b1, 1'b1, 1'b0);
        push_word(24'h77, 1'b1); push_word(24'h88, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b1);
        idle(1);
        check("post_reset_left", left_h, 24'h77);
        check("post_reset_right", right_m, 24'h88);

        // Randomized traffic, lock drops and occasional resets
        lk = 1'b1;
        lr = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) lk = !lk;
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) begin
                if ($urandom_range(0, 9) == 0) lr = !lr;
                push_word(24'($urandom), lr);
                lr = !lr;
            end
            if ($urandom_range(0, 399) == 0)
                step(1'b1, lk, 1'b0);
            else
                step(1'b0, lk, ($urandom_range(0, 5) == 0));
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
